// File: rtl/ysyx_23060208_isram.sv
// Instruction SRAM model for the fetch stage: fixed or LFSR-driven wait states,
// one-cycle ready pulse with held rdata, and a preload write port.
module ysyx_23060208_isram #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned              DEPTH_LOG2 = 10,
  parameter int unsigned              DELAY_BITS = 2,
  parameter bit                       RAND_EN    = 1'b1,
  parameter logic [7:0]               LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned           DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DELAY_BITS-1:0] CNT_ONE = 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DELAY_BITS-1:0]   cnt;
  logic [DELAY_BITS-1:0]   wait_init;
  logic [7:0]              lfsr;
  logic                    lfsr_fb;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   rd_off;
  logic [ADDR_WIDTH-1:0]   ld_off;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DEPTH_LOG2-1:0]   ld_idx;
  logic                    rd_ok;
  logic                    ld_ok;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Offsets wrap modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
  assign rd_off = addr_r - BASE_ADDR;
  assign ld_off = load_addr - BASE_ADDR;
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign ld_idx = ld_off[DEPTH_LOG2+1:2];
  assign rd_ok  = (rd_off[1:0] == 2'b00) && ((rd_off >> (DEPTH_LOG2 + 2)) == '0);
  assign ld_ok  = (ld_off[1:0] == 2'b00) && ((ld_off >> (DEPTH_LOG2 + 2)) == '0);

  // A preload hitting the word being read in the same cycle wins over the array.
  assign rd_word = (load_en && ld_ok && (ld_idx == rd_idx)) ? load_data : mem[rd_idx];

  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign wait_init = RAND_EN ? lfsr[DELAY_BITS-1:0] : {DELAY_BITS{1'b1}};

  always_ff @(posedge clk) begin
    if (load_en && ld_ok) begin
      mem[ld_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_r <= '0;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      rdata  <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr_fb};
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_r <= raddr;
            cnt    <= wait_init;
            state  <= WAIT;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= RESP;
            ready <= 1'b1;
            err   <= !rd_ok;
            rdata <= rd_ok ? rd_word : '0;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
